luhn_digit_tx: RTL

Serial Luhn check-digit generator and transmitter: the sending end of the card-number digit stream that `tt_um_creditCard` consumes and checks. It accepts a payload of BCD digits over a valid/ready input, buffers them, and computes the Luhn check digit. It then re-emits the payload followed by the check digit over a valid/ready output, with a last marker on the check digit. It sits between the digit source (ui_in capture logic or test stimulus) and the card checker.

---
 rtl/luhn_pkg.sv | 34 +++
 rtl/luhn_acc.sv | 65 ++++++
 rtl/luhn_digit_tx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/luhn_pkg.sv
// Shared types and helpers for the Luhn check-digit transmitter.
//
// Contents:
//   luhn_tx_state_t : transmitter FSM state encoding
//   LUHN_DBL        : Luhn "double and fold" table, index = digit 0..9
//   mod10_add       : add two digits 0..9, result 0..9
//   LUHN_MAX_DIGITS : default frame length including the check digit
package luhn_pkg;

    localparam int LUHN_MAX_DIGITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CALC  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DRAIN = 3'd4
    } luhn_tx_state_t;

    // 2*d with the two decimal digits summed (2*d - 9 when 2*d > 9).
    localparam logic [3:0] LUHN_DBL [0:9] = '{
        4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7, 4'd9
    };

    function automatic logic [3:0] mod10_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 5'd10) begin
            s = s - 5'd10;
        end
        return s[3:0];
    endfunction

endpackage

// File: rtl/luhn_acc.sv
// Pair of running mod-10 Luhn accumulators plus check-digit select.
//
// The payload length is not known until in_last, so both possible
// doubling phases are accumulated in parallel:
//   s_even doubles digits at even input index, s_odd at odd index.
// The rightmost payload digit must be doubled, so once the whole payload
// is in, an odd length selects s_even and an even length selects s_odd.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   digit    : digit being accepted
//   accept   : add digit into both accumulators this cycle
//   clear    : zero both accumulators (wins over accept)
//   idx_odd  : during accept, parity of the digit's index;
//              after the payload, parity of the payload length
//   check    : (10 - selected accumulator) mod 10
module luhn_acc
    import luhn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       accept,
    input  logic       clear,
    input  logic       idx_odd,
    output logic [3:0] check
);

    logic [3:0] s_even;
    logic [3:0] s_odd;
    logic [3:0] dbl;
    logic [3:0] plain;
    logic [3:0] sel;

    // Non-BCD digits contribute nothing, which keeps both sums in 0..9.
    always_comb begin
        dbl   = 4'd0;
        plain = 4'd0;
        if (digit <= 4'd9) begin
            dbl   = LUHN_DBL[digit];
            plain = digit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s_even <= 4'd0;
            s_odd  <= 4'd0;
        end else if (accept) begin
            if (idx_odd) begin
                s_odd  <= mod10_add(s_odd, dbl);
                s_even <= mod10_add(s_even, plain);
            end else begin
                s_even <= mod10_add(s_even, dbl);
                s_odd  <= mod10_add(s_odd, plain);
            end
        end
    end

    always_comb begin
        sel   = idx_odd ? s_even : s_odd;
        check = (sel == 4'd0) ? 4'd0 : (4'd10 - sel);
    end

endmodule

// File: rtl/luhn_digit_tx.sv
// Serial Luhn check-digit generator and transmitter.
//
// Buffers a BCD payload (MSD first), computes its Luhn check digit, then
// re-emits payload + check digit with out_last on the check digit.
// Input and output phases never overlap.
//
// Handshake (both sides): a beat transfers on a rising clk edge where
// valid & ready are both 1; the source holds data stable while valid & !ready.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   in_digit      : payload digit 0..9
//   in_valid      : in_digit / in_last valid
//   in_last       : final payload digit
//   in_ready      : block accepts a payload digit
//   out_digit     : transmitted digit (0 when out_valid is 0)
//   out_valid     : out_digit / out_last valid
//   out_last      : this beat is the check digit
//   out_ready     : downstream takes the beat
//   busy          : frame in progress (state != IDLE)
//   err           : one-cycle pulse when a frame is dropped
//   dbg_state     : current FSM state
//
// Configuration macro: LUHN_TX_BCD_CHECK_EN -- when defined, an accepted
// digit > 9 drops the frame with an err pulse.
module luhn_digit_tx
    import luhn_pkg::*;
#(
    parameter int MAX_DIGITS = LUHN_MAX_DIGITS
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     in_digit,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic [3:0]     out_digit,
    output logic           out_valid,
    output logic           out_last,
    input  logic           out_ready,
    output logic           busy,
    output logic           err,
    output luhn_tx_state_t dbg_state
);

    localparam int AW = $clog2(MAX_DIGITS);

    luhn_tx_state_t state;
    luhn_tx_state_t state_nxt;

    logic [AW-1:0] wr;
    logic [AW-1:0] rd;
    logic [3:0]    buf_mem [MAX_DIGITS];
    logic [3:0]    check;

    logic accept;
    logic frame_accept;
    logic overflow;
    logic bad_bcd;
    logic drop;
    logic beat;
    logic final_beat;

    assign dbg_state    = state;
    assign accept       = in_valid & in_ready;
    // Only IDLE/LOAD accepts belong to a frame; DRAIN accepts are discarded.
    assign frame_accept = accept & ((state == ST_IDLE) || (state == ST_LOAD));
    // The last slot is reserved for the check digit.
    assign overflow     = frame_accept & ~in_last & (wr == AW'(MAX_DIGITS - 2));
`ifdef LUHN_TX_BCD_CHECK_EN
    assign bad_bcd      = frame_accept & (in_digit > 4'd9);
`else
    assign bad_bcd      = 1'b0;
`endif
    assign drop         = overflow | bad_bcd;
    assign beat         = out_valid & out_ready;
    assign final_beat   = beat & (rd == wr);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE, ST_LOAD: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (bad_bcd) begin
                        state_nxt = in_last ? ST_IDLE : ST_DRAIN;
                    end else if (in_last) begin
                        state_nxt = ST_CALC;
                    end else if (overflow) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_CALC: begin
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                if (final_beat) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- counters / err ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr  <= '0;
            rd  <= '0;
            err <= 1'b0;
        end else begin
            err <= drop;
            if (frame_accept) begin
                wr <= drop ? '0 : (wr + AW'(1));
            end else if (state == ST_CALC) begin
                rd <= '0;
            end else if (beat) begin
                if (rd == wr) begin
                    wr <= '0;
                    rd <= '0;
                end else begin
                    rd <= rd + AW'(1);
                end
            end
        end
    end

    // Payload storage; the check digit lands in the slot after the payload.
    always_ff @(posedge clk) begin
        if (frame_accept && !drop) begin
            buf_mem[wr] <= in_digit;
        end else if (state == ST_CALC) begin
            buf_mem[wr] <= check;
        end
    end

    always_comb begin
        out_digit = out_valid ? buf_mem[rd] : 4'd0;
        out_last  = out_valid & (rd == wr);
    end

    // wr[0] is the index parity while loading and the length parity in CALC.
    luhn_acc u_acc (
        .clk     (clk),
        .rst     (rst),
        .digit   (in_digit),
        .accept  (frame_accept),
        .clear   (drop | final_beat),
        .idx_odd (wr[0]),
        .check   (check)
    );

endmodule
